prefetch_queue: RTL and testbench

Parametrised instruction prefetch unit that replaces the single-register fetch stage between instruction memory and decode. It issues in-order requests to a variable-latency instruction memory through a request/grant/response handshake and buffers up to DEPTH returned instructions with their PCs. It presents them to decode through a valid/ready handshake. On a taken branch or jump it flushes, discards in-flight responses and restarts fetch at the redirect target.

---
 rtl/prefetch_queue.sv | 108 ++++++++++
 tb/tb_prefetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: credit-limited in-order fetch from a variable-latency
// memory, DEPTH-entry {inst, pc} buffer toward decode, flush-and-discard on redirect.
module prefetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         redirect_i,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
  output logic                         im_req_o,
  output logic [ADDR_WIDTH-1:0]        im_addr_o,
  input  logic                         im_gnt_i,
  input  logic                         im_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        im_rdata_i,
  output logic                         inst_valid_o,
  output logic [DATA_WIDTH-1:0]        inst_o,
  output logic [ADDR_WIDTH-1:0]        inst_pc_o,
  input  logic                         inst_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int                    PTR_W   = $clog2(DEPTH);
  localparam int                    CNT_W   = $clog2(DEPTH+1);
  localparam int                    SUM_W   = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_discard;
  logic [DATA_WIDTH-1:0] r_inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];

  logic [SUM_W-1:0] w_credit_used;
  logic             w_req;
  logic             w_grant;
  logic             w_resp_keep;
  logic             w_resp_drop;
  logic             w_pop;

  // Stale responses still hold a memory slot, so they consume credit too.
  assign w_credit_used = SUM_W'(r_count) + SUM_W'(r_outstanding) + SUM_W'(r_discard);
  assign w_req         = rst_n_i & ~redirect_i & (w_credit_used < SUM_W'(DEPTH));
  assign w_grant       = w_req & im_gnt_i;
  assign w_resp_keep   = im_rvalid_i & ~redirect_i & (r_discard == '0);
  assign w_resp_drop   = im_rvalid_i & ~redirect_i & (r_discard != '0);
  assign w_pop         = (r_count != '0) & inst_ready_i & ~redirect_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_i) begin
      r_fetch_pc    <= redirect_pc_i;
      r_resp_pc     <= redirect_pc_i;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= r_discard + r_outstanding + CNT_W'(w_grant) - CNT_W'(im_rvalid_i);
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      if (w_resp_keep) begin
        r_resp_pc <= r_resp_pc + PC_STEP;
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
      end
      if (w_resp_drop) begin
        r_discard <= r_discard - CNT_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp_keep);
      r_count       <= r_count + CNT_W'(w_resp_keep) - CNT_W'(w_pop);
    end
  end

  // Queue storage carries no reset; empty entries are masked at the output.
  always_ff @(posedge clk_i) begin
    if (w_resp_keep) begin
      r_inst_mem[r_wr_ptr] <= im_rdata_i;
      r_pc_mem[r_wr_ptr]   <= r_resp_pc;
    end
  end

  assign im_req_o     = w_req;
  assign im_addr_o    = r_fetch_pc;
  assign inst_valid_o = (r_count != '0);
  assign inst_o       = inst_valid_o ? r_inst_mem[r_rd_ptr] : '0;
  assign inst_pc_o    = inst_valid_o ? r_pc_mem[r_rd_ptr] : '0;
  assign count_o      = r_count;

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized bench for prefetch_queue: a transaction-level memory and decode-side
// scoreboard predict every output each cycle, plus literal checks on key scenarios.
module tb_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  count;

  always #5 clk = ~clk;

  prefetch_queue #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .im_req_o(im_req), .im_addr_o(im_addr), .im_gnt_i(im_gnt),
    .im_rvalid_i(im_rvalid), .im_rdata_i(im_rdata),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc),
    .inst_ready_i(inst_ready), .count_o(count)
  );

  typedef struct { logic [31:0] addr; logic [31:0] mpc; int due; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        memq[$];   // granted requests not yet answered (stale or live)
  ent_t        bufq[$];   // what decode must see, head first
  logic [31:0] dq[$];     // PCs handed to decode, in order
  int          epoch = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_fetch = 32'h0;
  int          gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;
  logic        s_valid, s_req;
  logic [31:0] s_pc, s_addr;
  logic [2:0]  s_count;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance the model, move
  // to the next falling edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit   resp, pop, grant, exp_req;
    req_t r;
    int   due;
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = ($urandom_range(99) < ready_pct);
    im_gnt      = ($urandom_range(99) < gnt_pct);
    resp        = (memq.size() > 0) && (memq[0].due <= cyc);
    im_rvalid   = resp;
    im_rdata    = resp ? dat(memq[0].addr) : $urandom;
    #1;
    s_valid = inst_valid; s_req = im_req; s_pc = inst_pc; s_addr = im_addr; s_count = count;
    chk("inst_valid", 32'(inst_valid), 32'(bufq.size() != 0));
    chk("count", 32'(count), 32'(bufq.size()));
    if (bufq.size() != 0) begin
      chk("inst_pc", inst_pc, bufq[0].pc);
      chk("inst", inst, bufq[0].inst);
    end
    exp_req = !redir && ((bufq.size() + memq.size()) < DEPTH);
    chk("im_req", 32'(im_req), 32'(exp_req));
    chk("im_addr", im_addr, exp_fetch);
    grant = im_req && im_gnt;
    pop   = (bufq.size() != 0) && inst_ready && !redir;
    if (pop) begin
      dq.push_back(bufq[0].pc);
      void'(bufq.pop_front());
    end
    if (resp) begin
      r = memq.pop_front();
      if (!redir && r.epoch == epoch) bufq.push_back('{pc: r.mpc, inst: dat(r.mpc)});
    end
    if (grant) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
      memq.push_back('{addr: im_addr, mpc: exp_fetch, due: due, epoch: epoch});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      epoch++;
      bufq.delete();
      exp_fetch = rpc;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int n0;
    rst_n = 1'b1; redirect = 1'b0; redirect_pc = '0; im_gnt = 1'b0;
    im_rvalid = 1'b0; im_rdata = '0; inst_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req", 32'(im_req), 32'd0);
    chk("rst_addr", im_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;

    // Straight line: 1-cycle memory, always granted, always ready
    cycle(0, 0);
    chk("first_req", 32'(s_req), 32'd1);
    chk("first_addr", s_addr, 32'h0);
    chk("first_valid0", 32'(s_valid), 32'd0);
    cycle(0, 0);
    chk("first_valid1", 32'(s_valid), 32'd0);
    cycle(0, 0);
    chk("first_valid2", 32'(s_valid), 32'd1);
    chk("line_pc0", s_pc, 32'h0);
    cycle(0, 0);
    chk("line_pc4", s_pc, 32'h4);
    cycle(0, 0);
    chk("line_pc8", s_pc, 32'h8);
    repeat (10) cycle(0, 0);

    // Backpressure
    ready_pct = 0;
    repeat (10) cycle(0, 0);
    chk("full_count", 32'(s_count), 32'd4);
    chk("full_req", 32'(s_req), 32'd0);
    ready_pct = 100;
    repeat (12) cycle(0, 0);

    // Redirect with 3 outstanding at latency 3
    lat_min = 3; lat_max = 3;
    repeat (10) cycle(0, 0);
    for (int i = 0; i < 20 && memq.size() < 3; i++) cycle(0, 0);
    chk("three_outstanding", 32'(memq.size() >= 3), 32'd1);
    cycle(1, 32'h100);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(0, 0);
      if (s_valid) begin
        found = 1;
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    if (!found) chk("redir_timeout", 32'd0, 32'd1);
    repeat (5) cycle(0, 0);

    // Redirect together with ready while two entries wait
    lat_min = 1; lat_max = 1; ready_pct = 0;
    for (int i = 0; i < 20 && bufq.size() != 2; i++) cycle(0, 0);
    chk("two_waiting", 32'(bufq.size()), 32'd2);
    ready_pct = 100;
    n0 = dq.size();
    cycle(1, 32'h180);
    cycle(0, 0);
    chk("redir_ready_count", 32'(s_count), 32'd0);
    chk("redir_ready_valid", 32'(s_valid), 32'd0);
    chk("redir_ready_nopop", 32'(dq.size()), 32'(n0));
    repeat (5) cycle(0, 0);

    // Back-to-back redirects
    lat_min = 1; lat_max = 3;
    repeat (5) cycle(0, 0);
    cycle(1, 32'h200);
    cycle(1, 32'h300);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(0, 0);
      if (s_valid) begin
        found = 1;
        chk("b2b_first_pc", s_pc, 32'h300);
      end
    end
    if (!found) chk("b2b_timeout", 32'd0, 32'd1);
    repeat (20) cycle(0, 0);

    // Address wrap with random stalls and latencies
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 5;
    cycle(1, 32'hFFFF_FFF8);
    n0 = dq.size();
    for (int i = 0; i < 300 && dq.size() < n0 + 3; i++) cycle(0, 0);
    if (dq.size() >= n0 + 3) begin
      chk("wrap_pc0", dq[n0], 32'hFFFF_FFF8);
      chk("wrap_pc1", dq[n0+1], 32'hFFFF_FFFC);
      chk("wrap_pc2", dq[n0+2], 32'h0);
    end else begin
      chk("wrap_timeout", 32'(dq.size() - n0), 32'd3);
    end

    // Random soak with occasional redirects
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct   = $urandom_range(100, 20);
        ready_pct = $urandom_range(100, 10);
      end
      if ($urandom_range(99) < 3) cycle(1, $urandom & 32'hFFFF_FFFC);
      else cycle(0, 0);
    end
    gnt_pct = 100; ready_pct = 100;
    repeat (40) cycle(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
